// File: rtl/drive_mode_ctrl.sv
// Drive-mode controller: NS/S/M state machine with pedal-based engine start,
// latched direction, stall pulse, and an optional odometer (macro DRIVE_ODOMETER_EN).
module drive_mode_ctrl #(
  parameter int unsigned START_CYC = 4,
  parameter int unsigned TICK_DIV  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        power,
  input  logic        throttle,
  input  logic        clutch,
  input  logic        brake,
  input  logic        reverse,
  output logic [1:0]  state,
  output logic        dir,
  output logic        stall,
  output logic [15:0] odometer
);

  typedef enum logic [1:0] {
    ST_NS = 2'b00,
    ST_S  = 2'b01,
    ST_M  = 2'b10
  } state_e;

  localparam logic [7:0] START_LAST = 8'(START_CYC - 1);

  if (START_CYC < 1 || START_CYC > 255) begin : g_bad_start_cyc
    $error("drive_mode_ctrl: START_CYC out of range 1..255");
  end
  if (TICK_DIV < 1 || TICK_DIV > 65535) begin : g_bad_tick_div
    $error("drive_mode_ctrl: TICK_DIV out of range 1..65535");
  end

  state_e     state_q, state_d;
  logic [7:0] start_cnt_q, start_cnt_d;
  logic       dir_q, dir_d;
  logic       stall_q, stall_d;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    start_cnt_d = '0;
    stall_d     = 1'b0;
    dir_d       = (state_q == ST_M) ? dir_q : reverse;

    // Loss of power overrides every transition, including a pending start or stall.
    if (!power) begin
      state_d = ST_NS;
    end else begin
      unique case (state_q)
        ST_NS: begin
          if (throttle && clutch) begin
            // The counter tops out at START_CYC-1 and clears on the transition, so it never wraps.
            if (start_cnt_q == START_LAST) begin
              state_d = ST_S;
            end else begin
              start_cnt_d = start_cnt_q + 8'd1;
            end
          end
        end
        ST_S: begin
          if (throttle && !clutch) begin
            state_d = ST_M;
          end
        end
        ST_M: begin
          if (brake) begin
            if (clutch) begin
              state_d = ST_S;
            end else begin
              state_d = ST_NS;
              stall_d = 1'b1;
            end
          end
        end
        default: state_d = ST_NS;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q     <= ST_NS;
      start_cnt_q <= '0;
      dir_q       <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_cnt_q <= start_cnt_d;
      dir_q       <= dir_d;
      stall_q     <= stall_d;
    end
  end

  assign state = state_q;
  assign dir   = dir_q;
  assign stall = stall_q;

`ifdef DRIVE_ODOMETER_EN
  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic [15:0] odometer_q, odometer_d;

  always_comb begin
    tick_cnt_d = '0;
    odometer_d = odometer_q;
    if (state_q == ST_M) begin
      if (tick_cnt_q == TICK_LAST) begin
        if (odometer_q != 16'hFFFF) begin
          odometer_d = odometer_q + 16'd1;
        end
      end else begin
        tick_cnt_d = tick_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
      odometer_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      odometer_q <= odometer_d;
    end
  end

  assign odometer = odometer_q;
`else
  assign odometer = 16'h0000;
`endif

endmodule

// File: tb/tb_drive_mode_ctrl.sv
// Self-checking bench for drive_mode_ctrl: directed vector table, hand-written corner
// sequences, and randomized traffic against a behavioural model (DRIVE_ODOMETER_EN aware).
module tb_drive_mode_ctrl;

  localparam int START = 4;
  localparam int TICK  = 10;

  logic        clk = 1'b0;
  logic        rst, power, throttle, clutch, brake, reverse;
  logic [1:0]  state;
  logic        dir, stall;
  logic [15:0] odometer;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  drive_mode_ctrl #(.START_CYC(START), .TICK_DIV(TICK)) dut (
    .clk(clk), .rst(rst), .power(power), .throttle(throttle), .clutch(clutch),
    .brake(brake), .reverse(reverse), .state(state), .dir(dir), .stall(stall),
    .odometer(odometer)
  );

`ifdef DRIVE_ODOMETER_EN
  localparam int ODO_ON = 1;
  logic        b_rst = 1'b1, b_pw = 1'b0, b_th = 1'b0, b_cl = 1'b0, b_zero = 1'b0;
  logic [1:0]  b_state;
  logic        b_dir, b_stall;
  logic [15:0] b_odo;

  drive_mode_ctrl #(.START_CYC(START), .TICK_DIV(1)) dut_sat (
    .clk(clk), .rst(b_rst), .power(b_pw), .throttle(b_th), .clutch(b_cl),
    .brake(b_zero), .reverse(b_zero), .state(b_state), .dir(b_dir), .stall(b_stall),
    .odometer(b_odo)
  );
`else
  localparam int ODO_ON = 0;
`endif

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: state as 0/1/2, a run length of consecutive start conditions,
  // and distance as the odometer at M entry plus whole TICK periods spent in this M stay.
  int m_state = 0, m_run = 0, m_stay = 0, m_base = 0, m_odo = 0;
  int m_dir = 0, m_stall = 0;

  task automatic model_edge();
    int ns, nrun, ndir, nstall, nodo;
    if (rst) begin
      m_state = 0; m_run = 0; m_stay = 0; m_base = 0; m_odo = 0; m_dir = 0; m_stall = 0;
      return;
    end
    ndir   = (m_state == 2) ? m_dir : int'(reverse);
    nstall = (m_state == 2 && power && brake && !clutch) ? 1 : 0;
    nodo   = m_odo;
    if (m_state == 2) begin
      m_stay++;
      nodo = m_base + m_stay / TICK;
      if (nodo > 65535) nodo = 65535;
    end else begin
      m_stay = 0;
      m_base = m_odo;
    end
    ns = m_state;
    nrun = 0;
    if (!power) ns = 0;
    else if (m_state == 0) begin
      if (throttle && clutch) begin
        nrun = m_run + 1;
        if (nrun == START) begin ns = 1; nrun = 0; end
      end
    end else if (m_state == 1) begin
      if (throttle && !clutch) ns = 2;
    end else if (brake) begin
      ns = clutch ? 1 : 0;
    end
    m_state = ns; m_run = nrun; m_dir = ndir; m_stall = nstall;
    m_odo = (ODO_ON != 0) ? nodo : 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic r, p, t, c, b, v);
    rst = r; power = p; throttle = t; clutch = c; brake = b; reverse = v;
  endtask

  typedef struct {
    logic       rst, pw, th, cl, br, rv;
    logic [1:0] st;
    logic       dir, stall;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, p, t, c, b, v, input logic [1:0] s, input logic d, st_l);
    vec_t e;
    e.rst = r; e.pw = p; e.th = t; e.cl = c; e.br = b; e.rv = v;
    e.st = s; e.dir = d; e.stall = st_l;
    tbl.push_back(e);
  endtask

  logic [15:0] exp_odo;

  initial begin
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);

    // rst pw th cl br rv | state dir stall
    add(1,0,0,0,0,0, 2'b00,0,0);
    add(1,0,0,0,0,0, 2'b00,0,0);
    for (int i = 0; i < 3; i++) add(0,1,1,1,0,0, 2'b00,0,0);
    add(0,1,1,1,0,0, 2'b01,0,0);
    add(0,1,0,0,1,1, 2'b01,1,0);
    add(0,1,1,0,0,1, 2'b10,1,0);
    add(0,1,0,0,0,0, 2'b10,1,0);
    add(0,1,0,1,1,0, 2'b01,1,0);
    add(0,1,0,0,0,0, 2'b01,0,0);
    add(0,1,1,0,0,0, 2'b10,0,0);
    add(0,1,0,0,1,0, 2'b00,0,1);
    add(0,1,0,0,0,0, 2'b00,0,0);
    for (int i = 0; i < 3; i++) add(0,1,1,1,0,0, 2'b00,0,0);
    add(0,1,1,1,0,0, 2'b01,0,0);
    add(0,1,1,0,0,0, 2'b10,0,0);
    add(0,0,0,1,1,0, 2'b00,0,0);
    add(0,0,1,1,0,0, 2'b00,0,0);
    for (int i = 0; i < 3; i++) add(0,1,1,1,0,0, 2'b00,0,0);
    add(0,0,1,1,0,0, 2'b00,0,0);
    for (int i = 0; i < 3; i++) add(0,1,1,1,0,0, 2'b00,0,0);
    add(0,1,1,1,0,0, 2'b01,0,0);
    add(0,1,1,0,0,1, 2'b10,1,0);
    add(1,1,1,0,0,1, 2'b00,0,0);
    add(0,1,0,0,0,1, 2'b00,1,0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].pw, tbl[i].th, tbl[i].cl, tbl[i].br, tbl[i].rv);
      step();
      check($sformatf("tbl%0d_state", i), 16'(state), 16'(tbl[i].st));
      check($sformatf("tbl%0d_dir", i), 16'(dir), 16'(tbl[i].dir));
      check($sformatf("tbl%0d_stall", i), 16'(stall), 16'(tbl[i].stall));
      check($sformatf("tbl%0d_odo", i), odometer, 16'h0000);
    end

    // Interrupted start: 3 good edges, one clutch-up edge, then 4 more good edges needed.
    drive(1,0,0,0,0,0); step();
    drive(0,1,1,1,0,0);
    for (int i = 0; i < 3; i++) begin step(); check("intr_first_run", 16'(state), 16'h0); end
    drive(0,1,1,0,0,0); step(); check("intr_gap", 16'(state), 16'h0);
    drive(0,1,1,1,0,0);
    for (int i = 0; i < 3; i++) begin step(); check("intr_second_run", 16'(state), 16'h0); end
    step(); check("intr_started", 16'(state), 16'h1);

    // Odometer: 35 edges in M, leave via M->S, re-enter for 7 edges (tick must have cleared).
    drive(0,1,1,0,0,0); step(); check("odo_enter_m", 16'(state), 16'h2);
    drive(0,1,0,0,0,0);
    for (int i = 1; i <= 35; i++) begin
      step();
      if (i == 9)  check("odo_9", odometer, 16'h0000);
      if (i == 10) check("odo_10", odometer, (ODO_ON != 0) ? 16'h0001 : 16'h0000);
    end
    exp_odo = (ODO_ON != 0) ? 16'd3 : 16'd0;
    check("odo_35_state", 16'(state), 16'h2);
    check("odo_35", odometer, exp_odo);
    drive(0,1,0,1,1,0); step(); check("odo_to_s", 16'(state), 16'h1);
    drive(0,1,0,0,0,0); step(); check("odo_hold_in_s", odometer, exp_odo);
    drive(0,1,1,0,0,0); step();
    drive(0,1,0,0,0,0);
    for (int i = 0; i < 7; i++) step();
    check("odo_tick_cleared", odometer, exp_odo);

`ifdef DRIVE_ODOMETER_EN
    // Saturation on a TICK_DIV=1 instance: one odometer count per edge in M.
    b_rst = 1'b0; b_pw = 1'b1; b_th = 1'b1; b_cl = 1'b1;
    repeat (START) @(posedge clk);
    @(negedge clk);
    check("sat_started", 16'(b_state), 16'h1);
    b_cl = 1'b0;
    @(posedge clk); @(negedge clk);
    check("sat_in_m", 16'(b_state), 16'h2);
    b_th = 1'b0;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    check("sat_fffe", b_odo, 16'hFFFE);
    @(posedge clk); @(negedge clk);
    check("sat_ffff", b_odo, 16'hFFFF);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("sat_hold", b_odo, 16'hFFFF);
`endif

    // Randomized traffic against the model.
    drive(1,0,0,0,0,0); step();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(199) == 0, $urandom_range(31) != 0, 1'($urandom_range(1)),
            1'($urandom_range(1)), $urandom_range(7) == 0, 1'($urandom_range(1)));
      step();
      check($sformatf("rnd%0d_state", i), 16'(state), 16'(m_state));
      check($sformatf("rnd%0d_dir", i), 16'(dir), 16'(m_dir));
      check($sformatf("rnd%0d_stall", i), 16'(stall), 16'(m_stall));
      check($sformatf("rnd%0d_odo", i), odometer, 16'(m_odo));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
